// File: rtl/if_stage_fetch.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Owns the PC, keeps at most one instruction-memory request in flight, absorbs one
// response in a depth-1 skid buffer while decode is stalled, and flushes on EX redirects.
module if_stage_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall_d,
  input  logic        redirect_e,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d
);

  typedef enum logic [1:0] {
    StRun,
    StHold,
    StDiscard
  } state_e;

  state_e      state;
  logic [31:0] pc_f;
  logic [31:0] req_pc;
  logic        outstanding;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;
  logic        resp;

  assign imem_addr = pc_f;

  // Only a response to our own request counts; anything else is stale.
  assign resp = imem_rvalid && outstanding;

  // A new request may be issued in the same cycle the previous one is consumed.
  always_comb begin
    imem_req = !rst && !redirect_e && (state == StRun) &&
               (!outstanding || (imem_rvalid && !stall_d));
  end

  // PC, request tracking, skid buffer, state and IF/ID register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= StRun;
      pc_f        <= RESET_PC;
      req_pc      <= RESET_PC;
      outstanding <= 1'b0;
      skid_instr  <= NOP_INSTR;
      skid_pc     <= 32'h0;
      valid_d     <= 1'b0;
      instr_d     <= NOP_INSTR;
      pc_d        <= 32'h0;
      pc_plus4_d  <= 32'h0;
    end else if (redirect_e) begin
      pc_f       <= redirect_pc;
      valid_d    <= 1'b0;
      instr_d    <= NOP_INSTR;
      skid_instr <= NOP_INSTR;
      skid_pc    <= 32'h0;
      if (state == StDiscard) begin
        // Still waiting for the stale response; a same-cycle arrival retires it.
        if (imem_rvalid) begin
          outstanding <= 1'b0;
          state       <= StRun;
        end
      end else if (outstanding && !imem_rvalid) begin
        state <= StDiscard;
      end else begin
        // Any response arriving this cycle belongs to the wrong path and is dropped.
        outstanding <= 1'b0;
        state       <= StRun;
      end
    end else begin
      if (imem_req) begin
        req_pc      <= pc_f;
        pc_f        <= pc_f + 32'd4;
        outstanding <= 1'b1;
      end
      case (state)
        StRun: begin
          if (resp && !stall_d) begin
            valid_d    <= 1'b1;
            instr_d    <= imem_rdata;
            pc_d       <= req_pc;
            pc_plus4_d <= req_pc + 32'd4;
          end else if (resp && stall_d) begin
            skid_instr  <= imem_rdata;
            skid_pc     <= req_pc;
            outstanding <= 1'b0;
            state       <= StHold;
          end else if (!stall_d) begin
            valid_d <= 1'b0;
            instr_d <= NOP_INSTR;
          end
        end
        StHold: begin
          if (!stall_d) begin
            valid_d    <= 1'b1;
            instr_d    <= skid_instr;
            pc_d       <= skid_pc;
            pc_plus4_d <= skid_pc + 32'd4;
            state      <= StRun;
          end
        end
        StDiscard: begin
          if (imem_rvalid) begin
            outstanding <= 1'b0;
            state       <= StRun;
          end
        end
        default: state <= StRun;
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage_fetch.sv
// Self-checking bench for if_stage_fetch: per-cycle vector table plus hand sequences
// for discard-after-redirect, reset during a skid hold and PC wrap-around.
module tb_if_stage_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        stall_d = 1'b0;
  logic        redirect_e = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4_d;
  logic        valid_d;

  // Second instance exercising the wrap-around reset PC.
  logic        rst2 = 1'b1;
  logic        imem_req2;
  logic [31:0] imem_addr2;
  logic        imem_rvalid2 = 1'b0;
  logic [31:0] imem_rdata2 = 32'h0;
  logic        zero_bit = 1'b0;
  logic [31:0] zero_word = 32'h0;
  logic [31:0] instr_d2;
  logic [31:0] pc_d2;
  logic [31:0] pc_plus4_d2;
  logic        valid_d2;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  if_stage_fetch u_dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .stall_d    (stall_d),
    .redirect_e (redirect_e),
    .redirect_pc(redirect_pc),
    .instr_d    (instr_d),
    .pc_d       (pc_d),
    .pc_plus4_d (pc_plus4_d),
    .valid_d    (valid_d)
  );

  if_stage_fetch #(
    .RESET_PC (32'hFFFF_FFFC),
    .NOP_INSTR(32'h0000_0013)
  ) u_dut_wrap (
    .clk        (clk),
    .rst        (rst2),
    .imem_req   (imem_req2),
    .imem_addr  (imem_addr2),
    .imem_rvalid(imem_rvalid2),
    .imem_rdata (imem_rdata2),
    .stall_d    (zero_bit),
    .redirect_e (zero_bit),
    .redirect_pc(zero_word),
    .instr_d    (instr_d2),
    .pc_d       (pc_d2),
    .pc_plus4_d (pc_plus4_d2),
    .valid_d    (valid_d2)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0003;
  endfunction

  // Memory model for u_dut: in-order responses, 'lat' cycles after the request cycle.
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;
  mreq_t mq[$];
  int    cyc_n = 0;
  int    lat = 1;

  always @(posedge clk) begin
    #1;
    cyc_n++;
    if (mq.size() > 0 && mq[0].due <= cyc_n) begin
      imem_rvalid = 1'b1;
      imem_rdata  = instr_of(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      mq.delete();
      imem_rvalid = 1'b0;
    end else if (imem_req) begin
      mq.push_back('{addr: imem_addr, due: cyc_n + lat});
    end
  end

  // Memory model for u_dut_wrap: fixed 1-cycle latency.
  logic        pend2 = 1'b0;
  logic [31:0] pend2_addr = 32'h0;

  always @(negedge clk) begin
    pend2      = imem_req2;
    pend2_addr = imem_addr2;
  end

  always @(posedge clk) begin
    #1;
    imem_rvalid2 = pend2 && !rst2;
    imem_rdata2  = instr_of(pend2_addr);
  end

  typedef struct {
    logic        r;
    logic        s;
    logic        x;
    logic [31:0] p;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_p4;
  } vec_t;
  vec_t vt[22];

  task automatic cyc(input logic r, input logic s, input logic x, input logic [31:0] p);
    @(posedge clk);
    #2;
    rst         = r;
    stall_d     = s;
    redirect_e  = x;
    redirect_pc = p;
    @(negedge clk);
  endtask

  task automatic cmp32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic check(input string nm, input logic e_req, input logic [31:0] e_addr,
                       input logic e_valid, input logic [31:0] e_pc, input logic [31:0] e_p4);
    logic [31:0] e_instr;
    e_instr = e_valid ? instr_of(e_pc) : NOP;
    n_vec++;
    if (imem_req !== e_req || imem_addr !== e_addr || valid_d !== e_valid ||
        pc_d !== e_pc || pc_plus4_d !== e_p4 || instr_d !== e_instr) begin
      n_bad++;
      $display("FAIL %s: got req=%0b addr=%h valid=%0b pc=%h p4=%h instr=%h, expected req=%0b addr=%h valid=%0b pc=%h p4=%h instr=%h",
               nm, imem_req, imem_addr, valid_d, pc_d, pc_plus4_d, instr_d,
               e_req, e_addr, e_valid, e_pc, e_p4, e_instr);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic found;
    logic seen_req;
    logic done;

    // r, s, x, redirect_pc | req, addr, valid, pc_d, pc_plus4_d
    vt[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h00,  1'b0, 32'h00,  32'h00};
    vt[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h00,  1'b0, 32'h00,  32'h00};
    vt[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h04,  1'b0, 32'h00,  32'h00};
    vt[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h08,  1'b1, 32'h00,  32'h04};
    vt[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h0C,  1'b1, 32'h04,  32'h08};
    vt[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h10,  1'b1, 32'h08,  32'h0C};
    vt[6]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h14,  1'b1, 32'h0C,  32'h10};
    vt[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h00,  1'b0, 32'h00,  32'h00};
    vt[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h04,  1'b0, 32'h00,  32'h00};
    vt[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h08,  1'b1, 32'h00,  32'h04};
    vt[10] = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0C,  1'b1, 32'h04,  32'h08};
    vt[11] = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0C,  1'b1, 32'h04,  32'h08};
    vt[12] = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0C,  1'b1, 32'h04,  32'h08};
    vt[13] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0C,  1'b1, 32'h04,  32'h08};
    vt[14] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h0C,  1'b1, 32'h08,  32'h0C};
    vt[15] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h10,  1'b0, 32'h08,  32'h0C};
    vt[16] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h14,  1'b1, 32'h0C,  32'h10};
    vt[17] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h18,  1'b1, 32'h10,  32'h14};
    vt[18] = '{1'b0, 1'b1, 1'b1, 32'h200, 1'b0, 32'h1C,  1'b1, 32'h14,  32'h18};
    vt[19] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h200, 1'b0, 32'h14,  32'h18};
    vt[20] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h204, 1'b0, 32'h14,  32'h18};
    vt[21] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h208, 1'b1, 32'h200, 32'h204};

    repeat (2) @(posedge clk);

    // Streaming, re-reset, stall into skid, redirect+stall together.
    for (int i = 0; i < 22; i++) begin
      cyc(vt[i].r, vt[i].s, vt[i].x, vt[i].p);
      check($sformatf("vec%0d", i), vt[i].e_req, vt[i].e_addr, vt[i].e_valid,
            vt[i].e_pc, vt[i].e_p4);
    end

    // Reset asserted while holding a skidded instruction.
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    check("hold_rst_c1", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    check("hold_rst_c2", 1'b1, 32'h4, 1'b0, 32'h0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    check("hold_rst_c3", 1'b0, 32'h8, 1'b1, 32'h0, 32'h4);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    check("hold_rst_in_hold", 1'b0, 32'h8, 1'b1, 32'h0, 32'h4);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    check("hold_rst_after", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);

    // 3-cycle memory, redirect one cycle after the request for 0x10.
    lat = 3;
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 32'h0);
      if (imem_req && imem_addr == 32'h10) found = 1'b1;
    end
    cmp32("disc_req10_seen", {31'h0, found}, 32'h1);
    cyc(1'b0, 1'b0, 1'b1, 32'h100);
    cmp32("disc_redirect_noreq", {31'h0, imem_req}, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    cmp32("disc_wait_noreq", {31'h0, imem_req}, 32'h0);
    cmp32("disc_wait_addr", imem_addr, 32'h100);
    cmp32("disc_wait_valid", {31'h0, valid_d}, 32'h0);
    cmp32("disc_wait_instr", instr_d, NOP);
    seen_req = 1'b0;
    done     = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 32'h0);
      if (imem_req && !seen_req) begin
        seen_req = 1'b1;
        cmp32("disc_first_addr", imem_addr, 32'h100);
      end
      if (valid_d) begin
        done = 1'b1;
        cmp32("disc_first_pc", pc_d, 32'h100);
        cmp32("disc_first_instr", instr_d, instr_of(32'h100));
        cmp32("disc_first_p4", pc_plus4_d, 32'h104);
      end
    end
    cmp32("disc_valid_seen", {31'h0, done}, 32'h1);

    // Wrap-around reset PC on the second instance.
    @(posedge clk);
    #2;
    rst2 = 1'b0;
    @(negedge clk);
    cmp32("wrap_req1", {31'h0, imem_req2}, 32'h1);
    cmp32("wrap_addr1", imem_addr2, 32'hFFFF_FFFC);
    cmp32("wrap_valid0", {31'h0, valid_d2}, 32'h0);
    @(negedge clk);
    cmp32("wrap_addr2", imem_addr2, 32'h0);
    @(negedge clk);
    cmp32("wrap_valid1", {31'h0, valid_d2}, 32'h1);
    cmp32("wrap_pc", pc_d2, 32'hFFFF_FFFC);
    cmp32("wrap_p4", pc_plus4_d2, 32'h0);
    cmp32("wrap_instr", instr_d2, instr_of(32'hFFFF_FFFC));
    @(negedge clk);
    cmp32("wrap_pc_next", pc_d2, 32'h0);
    cmp32("wrap_p4_next", pc_plus4_d2, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
